// File: rtl/aes_pkg.sv
// Shared AES byte-substitution types and constants.
// Holds the engine state enum and block geometry.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

endpackage

// File: rtl/sbox_lane.sv
// One combinational AES S-box lane, forward or inverse.
// Ports: byte_in, inverse (1 = inverse table), byte_out.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              inverse,
  output logic [BYTE_W-1:0] byte_out
);

  // Entry 0 sits in the top byte of each table.
  localparam logic [2047:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Bit offset of entry x is (255 - x) * 8 = {~x, 3'b000}.
  logic [10:0] pos;

  always_comb begin
    pos      = {~byte_in, 3'b000};
    byte_out = inverse ? INV[pos +: BYTE_W] : FWD[pos +: BYTE_W];
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Multi-beat AES SubBytes engine, LANES S-boxes per cycle.
// Ports: clk, n_rst, in_* / out_* valid-ready, clear, busy.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic         in_inverse,
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int BEATS = BLOCK_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LW = LANES * BYTE_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [127:0] LOW_MASK =
    {128{1'b1}} >> (128 - LW);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     work;
  logic             mode;

  logic [LW-1:0]    lane_in;
  logic [LW-1:0]    lane_out;
  logic [127:0]     shifted;
  logic [127:0]     merged;
  int unsigned      sh;

  // Select the current beat's bytes and splice results back.
  always_comb begin
    sh      = 32'(cnt) * LW;
    shifted = work >> sh;
    lane_in = shifted[LW-1:0];
    merged  = (work & ~(LOW_MASK << sh)) |
              (128'(lane_out) << sh);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .byte_in  (lane_in[l*BYTE_W +: BYTE_W]),
      .inverse  (mode),
      .byte_out (lane_out[l*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      mode      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_block;
            mode     <= in_inverse;
            cnt      <= '0;
            state    <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          work <= merged;
          if (cnt == LAST) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_block = work;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine at LANES 1, 2, 4, 16.
// Index 0:L1, 1:L2, 2:L4, 3:L16.
module tb_sub_bytes_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         n_rst;
  logic [3:0]   iv, ii, clr, ordy;
  wire  [3:0]   ir, ov, bz;
  logic [127:0] ib [4];
  wire  [127:0] ob [4];

  int total = 0;
  int bad   = 0;

  sub_bytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .n_rst(n_rst),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_block(ib[0]), .in_inverse(ii[0]),
    .clear(clr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_block(ob[0]), .busy(bz[0])
  );

  sub_bytes_engine #(.LANES(2)) u_l2 (
    .clk(clk), .n_rst(n_rst),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_block(ib[1]), .in_inverse(ii[1]),
    .clear(clr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_block(ob[1]), .busy(bz[1])
  );

  sub_bytes_engine #(.LANES(4)) u_l4 (
    .clk(clk), .n_rst(n_rst),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_block(ib[2]), .in_inverse(ii[2]),
    .clear(clr[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_block(ob[2]), .busy(bz[2])
  );

  sub_bytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .n_rst(n_rst),
    .in_valid(iv[3]), .in_ready(ir[3]),
    .in_block(ib[3]), .in_inverse(ii[3]),
    .clear(clr[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]),
    .out_block(ob[3]), .busy(bz[3])
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one block, then time and collect the result.
  task automatic run(input int k,
                     input logic [127:0] blk,
                     input logic inv,
                     output logic [127:0] res,
                     output int lat);
    int n;
    n = 0;
    @(negedge clk);
    iv[k] = 1'b1;
    ib[k] = blk;
    ii[k] = inv;
    while (!ir[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    ib[k] = ~blk;
    ii[k] = ~inv;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = ob[k];
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] r, r2, blk, exp;
    logic [7:0]   xs [16];
    logic [7:0]   ys [16];
    logic         seen;
    int           lat, n, k;

    xs = '{8'h00, 8'h01, 8'h19, 8'h53, 8'h52, 8'hff, 8'h10, 8'h80,
           8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h90, 8'ha0};
    ys = '{8'h63, 8'h7c, 8'hd4, 8'hed, 8'h00, 8'h16, 8'hca, 8'hcd,
           8'hb7, 8'h04, 8'h09, 8'h53, 8'hd0, 8'h51, 8'h60, 8'he0};

    n_rst = 1'b0;
    iv = '0; ii = '0; clr = '0; ordy = '0;
    for (int i = 0; i < 4; i++) ib[i] = '0;
    #12;
    check("rst_l4", {ir[2], ov[2], bz[2], ob[2]},
          {3'b100, 128'h0});
    check("rst_l16", {ir[3], ov[3], bz[3], ob[3]},
          {3'b100, 128'h0});
    @(negedge clk);
    n_rst = 1'b1;

    run(2, {16{8'h00}}, 1'b0, r, lat);
    check("fwd00", r, {16{8'h63}});
    check("lat4", lat, 4);
    run(2, {16{8'h63}}, 1'b1, r, lat);
    check("inv63", r, {16{8'h00}});
    run(2, {16{8'h00}}, 1'b1, r, lat);
    check("inv00", r, {16{8'h52}});

    for (int i = 0; i < 16; i++) begin
      blk[8*i +: 8] = xs[i];
      exp[8*i +: 8] = ys[i];
    end
    run(2, blk, 1'b0, r, lat);
    check("dir_fwd_l4", r, exp);
    run(1, exp, 1'b1, r, lat);
    check("dir_inv_l2", r, blk);
    check("lat8", lat, 8);

    for (int j = 0; j < 2; j++) begin
      k = (j == 0) ? 0 : 3;
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(b * 16 + i);
        run(k, blk, 1'b0, r, lat);
        if (b == 0) check("sweep_lat", lat, (k == 0) ? 16 : 1);
        if (b == 1) check("s19", r[8*9 +: 8], 8'hd4);
        if (b == 5) check("s53", r[8*3 +: 8], 8'hed);
        run(k, r, 1'b1, r2, lat);
        if (b == 13) check("inv_ed", r2[8*3 +: 8], 8'hd3);
        check("roundtrip", r2, blk);
      end
    end

    @(negedge clk);
    iv[2] = 1'b1;
    ib[2] = {16{8'h01}};
    ii[2] = 1'b0;
    @(posedge clk);
    #1;
    ib[2] = {16{8'h10}};
    n = 0;
    while (!ov[2] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_lat", n, 4);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {ov[2], ir[2], ob[2]},
            {2'b10, {16{8'h7c}}});
      @(posedge clk);
      #1;
    end
    ordy[2] = 1'b1;
    @(posedge clk);
    #1;
    ordy[2] = 1'b0;
    check("bp_hs", {ov[2], ir[2], bz[2]}, 3'b010);
    @(posedge clk);
    #1;
    check("bp_acc", {ir[2], bz[2]}, 2'b01);
    iv[2] = 1'b0;
    n = 0;
    while (!ov[2] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_next", ob[2], {16{8'hca}});
    ordy[2] = 1'b1;
    @(posedge clk);
    #1;
    ordy[2] = 1'b0;

    @(negedge clk);
    iv[1] = 1'b1;
    ib[1] = {16{8'h00}};
    ii[1] = 1'b0;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clr[1] = 1'b1;
    @(posedge clk);
    #1;
    clr[1] = 1'b0;
    check("clr_idle", {ir[1], bz[1], ov[1]}, 3'b100);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (ov[1]) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("clr_noout", seen, 1'b0);
    iv[1] = 1'b1;
    clr[1] = 1'b1;
    @(posedge clk);
    #1;
    clr[1] = 1'b0;
    iv[1] = 1'b0;
    check("clr_noacc", {ir[1], bz[1]}, 2'b10);
    run(1, {16{8'h53}}, 1'b0, r, lat);
    check("clr_after", r, {16{8'hed}});

    @(negedge clk);
    iv[2] = 1'b1;
    ib[2] = {16{8'hff}};
    ii[2] = 1'b0;
    @(posedge clk);
    #1;
    iv[2] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", bz[2], 1'b1);
    n_rst = 1'b0;
    #1;
    check("rst_mid", {ir[2], ov[2], bz[2], ob[2]},
          {3'b100, 128'h0});
    @(negedge clk);
    n_rst = 1'b1;
    run(2, {16{8'h01}}, 1'b0, r, lat);
    check("rst_after", r, {16{8'h7c}});
    check("rst_lat", lat, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_engine.md
SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

Interface
REQ-001 SHALL have parameter LANES, default 4, giving the number of S-box lanes evaluated per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have derived constant BEATS = 16/LANES, giving the number of cycles needed per 128-bit block.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a block is offered on the input side.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine can accept a block.
REQ-007 SHALL have port in_block, input, 128 bits: the block, with byte i at bits [8i+7:8i].
REQ-008 SHALL have port in_inverse, input, 1 bit: 1 selects the inverse S-box, 0 selects the forward S-box.
REQ-009 SHALL have port clear, input, 1 bit: synchronous abort.
REQ-010 SHALL have port out_valid, output, 1 bit: out_block holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_block, output, 128 bits: the substituted block, using the same byte order as in_block.
REQ-013 SHALL have port busy, output, 1 bit: the engine is in state SUB or DONE.

Function
REQ-014 SHALL implement an FSM with states IDLE, SUB and DONE, together with beat counter cnt of width clog2(BEATS), minimum 1 bit.
REQ-015 SHALL assert in_ready only in IDLE; a transfer occurs on a rising edge where in_valid && in_ready.
REQ-016 SHALL, on an input transfer, latch in_block into the working register and in_inverse into the mode register, set cnt = 0 and enter SUB.
REQ-017 SHALL, in SUB on each cycle, replace working bytes cnt*LANES .. cnt*LANES+LANES-1 with S(byte) or S^-1(byte), selected by the latched mode, and increment cnt.
REQ-018 SHALL, in SUB when cnt == BEATS-1, perform the final beat, reset cnt to 0 and enter DONE.
REQ-019 SHALL assert out_valid only in DONE, with out_block equal to the working register.
REQ-020 SHALL, in DONE, hold out_valid and out_block stable until out_ready is sampled high, then enter IDLE.
REQ-021 SHALL give a latency of exactly BEATS cycles from the input-transfer edge to out_valid rising; for LANES=16 this is 1 cycle.
REQ-022 SHALL sustain a maximum throughput of one block per BEATS+2 cycles; a new block is not accepted in the same cycle that a result is consumed.
REQ-023 SHALL ignore changes on in_block and in_inverse after acceptance; the mode is fixed per block.
REQ-024 SHALL, when clear is high, enter IDLE and zero cnt on the next edge in any state, discarding the block with no out_valid for it; clear takes priority over an input transfer and over out_ready.
REQ-025 SHALL, when clear is asserted in IDLE with in_valid high, not accept the offered block.
REQ-026 SHALL compute the forward S-box per FIPS-197 and the inverse S-box as its exact inverse, so that S^-1(S(x)) = x for all 256 values of x.
REQ-027 SHALL drive out_block only from a register, never combinationally from the S-box lanes.

Reset
REQ-028 SHALL, while n_rst is low, hold state = IDLE, cnt = 0, working register = 0 and mode = 0, regardless of clk.
REQ-029 SHALL produce reset output values in_ready = 1, out_valid = 0, busy = 0 and out_block = 128'h0.
REQ-030 SHALL, when reset is asserted mid-block, discard the block; after release, the first accepted block processes normally.

Structure
REQ-031 SHALL place the state enum (IDLE, SUB, DONE) and the constants BLOCK_BYTES = 16 and BYTE_W = 8 in shared package aes_pkg.
REQ-032 SHALL use one sub-module, sbox_lane: a combinational 8-bit lane with inputs byte_in and inverse and output byte_out, containing both 256-entry tables, instantiated LANES times.
REQ-033 SHALL reject an illegal LANES value at elaboration.

Verification
REQ-034 LANES=4, forward, in_block all bytes 8'h00 -> out_valid 4 cycles after acceptance, out_block all bytes 8'h63.
REQ-035 LANES=4, inverse, in_block all bytes 8'h63 -> out_block all 8'h00; then inverse on all 8'h00 -> all 8'h52.
REQ-036 LANES=1 and LANES=16, exhaustive sweep: forward on byte value x followed by inverse on the result returns x for all 256 values, e.g. 8'h19 -> 8'hd4 -> 8'h19 and 8'h53 -> 8'hed -> 8'h53; latency is 16 and 1 respectively.
REQ-037 Backpressure: out_ready held low for 10 cycles -> out_valid and out_block stable throughout, in_ready stays 0, and a new in_valid is not accepted until the cycle after the out_ready handshake.
REQ-038 clear asserted at beat 2 of a LANES=2 block -> IDLE next cycle, no out_valid for that block, and a following block produces a correct result.
REQ-039 n_rst asserted mid-SUB -> outputs return immediately to their reset values; after release, a forward all-8'h01 block yields all 8'h7c.
